alu_bf16: RTL and testbench

ALU_BF16 -- requirements
Module: alu_bf16

---
 rtl/alu_fp_pkg.sv | 18 +
 rtl/fp_round_pack.sv | 27 ++
 rtl/alu_bf16.sv | 65 ++++++
 tb/tb_alu_bf16.sv | 104 ++++++++++
 4 files changed

// File: rtl/alu_fp_pkg.sv
// alu_fp_pkg: opcodes, bf16 field layout and shared helpers for the fp ALUs
package alu_fp_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BIAS = 127;
  localparam logic [15:0] NAN_C = 16'h7FC0;
  typedef struct packed {
    logic s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } bf16_t;
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i <= 10; i++) if (v[i]) lzc11 = 4'(10 - i);
  endfunction
endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalize {carry,hidden,frac7,g,r,s}, round to nearest even, range-check and pack bf16
module fp_round_pack import alu_fp_pkg::*; (
  input  logic              sign,
  input  logic signed [9:0] expo,
  input  logic [11:0]       sig,
  output logic [15:0]       y
);
  logic [3:0] lz;
  logic [10:0] n;
  logic signed [9:0] en, ef;
  logic rup;
  logic [8:0] m9;
  logic [6:0] frac;
  // one-step right shift on carry, else left shift by leading zeros; then RNE and exponent range check
  always_comb begin
    lz = lzc11(sig[10:0]);
    n = sig[11] ? {sig[11:2], |sig[1:0]} : sig[10:0] << lz;
    en = sig[11] ? expo + 10'sd1 : expo - signed'({6'd0, lz});
    rup = n[2] & (n[1] | n[0] | n[3]);
    m9 = {1'b0, n[10:3]} + {8'd0, rup};
    ef = en + signed'({9'd0, m9[8]});
    frac = m9[8] ? m9[7:1] : m9[6:0];
    y = sig == '0 ? 16'h0000 :
        ef >= 10'sd255 ? {sign, 8'hFF, 7'h00} :
        ef <= 10'sd0 ? 16'h0000 : {sign, ef[7:0], frac};
  end
endmodule

// File: rtl/alu_bf16.sv
// alu_bf16: registered bf16 add/multiply with IEEE-style special-value handling
module alu_bf16 import alu_fp_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  alu_ctrl,
  output logic [15:0] y
);
  bf16_t fa, fb;
  logic za, zb, ia, ib, na, nb, swap, sl, ss, is_mul, rp_s;
  logic [7:0] ma, mb, ml, ms, el, es, d;
  logic [4:0] sh;
  logic [31:0] al;
  logic [10:0] lx, sx;
  logic [11:0] add_sig, mul_sig, rp_sig;
  logic [15:0] p, rp_y, add_y, mul_y, y_next;
  logic signed [9:0] mul_exp, rp_exp;
  assign fa = a;
  assign fb = b;
  // subnormals carry a zero significand so they behave as zero through both datapaths
  always_comb begin
    za = fa.e == '0;
    zb = fb.e == '0;
    ia = &fa.e && fa.m == '0;
    ib = &fb.e && fb.m == '0;
    na = &fa.e && fa.m != '0;
    nb = &fb.e && fb.m != '0;
    ma = za ? 8'h00 : {1'b1, fa.m};
    mb = zb ? 8'h00 : {1'b1, fb.m};
    swap = b[14:0] > a[14:0];
    sl = swap ? fb.s : fa.s;
    ss = swap ? fa.s : fb.s;
    el = swap ? fb.e : fa.e;
    es = swap ? fa.e : fb.e;
    ml = swap ? mb : ma;
    ms = swap ? ma : mb;
    d = el - es;
    sh = d > 8'd31 ? 5'd31 : d[4:0];
    al = {ms, 24'd0} >> sh;
    lx = {ml, 3'b000};
    sx = {al[31:22], |al[21:0]};
    add_sig = sl == ss ? {1'b0, lx} + {1'b0, sx} : {1'b0, lx} - {1'b0, sx};
    p = ma * mb;
    mul_sig = {p[15:5], |p[4:0]};
    mul_exp = signed'({2'b00, fa.e}) + signed'({2'b00, fb.e}) - 10'(BIAS);
    is_mul = alu_ctrl == ALU_MUL;
    rp_s = is_mul ? fa.s ^ fb.s : sl;
    rp_exp = is_mul ? mul_exp : signed'({2'b00, el});
    rp_sig = is_mul ? mul_sig : add_sig;
    add_y = (na | nb | (ia & ib & (fa.s != fb.s))) ? NAN_C :
            (ia | ib) ? {ia ? fa.s : fb.s, 8'hFF, 7'h00} : rp_y;
    mul_y = (na | nb | (ia & zb) | (ib & za)) ? NAN_C :
            (ia | ib) ? {fa.s ^ fb.s, 8'hFF, 7'h00} : rp_y;
    y_next = alu_ctrl == ALU_ADD ? add_y : is_mul ? mul_y : 16'h0000;
  end
  fp_round_pack u_rp (
    .sign(rp_s),
    .expo(rp_exp),
    .sig(rp_sig),
    .y(rp_y)
  );
  // single output register; reset loads zero
  always_ff @(posedge clock) y <= reset ? 16'h0000 : y_next;
endmodule

// File: tb/tb_alu_bf16.sv
// tb_alu_bf16: directed bf16 ADD/MUL vectors with hand-computed results
module tb_alu_bf16;
  logic clock = 1'b0;
  logic reset;
  logic [15:0] a, b, y;
  logic [3:0] alu_ctrl;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [3:0] ADD = 4'b0001, MUL = 4'b0010;

  alu_bf16 dut (
    .clock(clock),
    .reset(reset),
    .a(a),
    .b(b),
    .alu_ctrl(alu_ctrl),
    .y(y)
  );

  always #5 clock = ~clock;

  task automatic check(input logic [15:0] exp_y, input string tag);
    n_cmp++;
    assert (y === exp_y) else begin
      n_bad++;
      $error("FAIL %s: y=%h expected %h", tag, y, exp_y);
    end
  endtask

  task automatic run(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] op,
                     input logic [15:0] exp_y, input string tag);
    @(negedge clock);
    a = ta;
    b = tb;
    alu_ctrl = op;
    @(posedge clock);
    #1;
    check(exp_y, tag);
  endtask

  initial begin
    reset = 1'b1;
    a = 16'h1234;
    b = 16'h5678;
    alu_ctrl = ADD;
    repeat (2) @(posedge clock);
    #1;
    check(16'h0000, "reset_state");
    @(negedge clock);
    reset = 1'b0;
    run(16'h3F80, 16'hBF80, ADD, 16'h0000, "add_x_minus_x");
    run(16'h0000, 16'h0000, ADD, 16'h0000, "add_zero_zero");
    run(16'hBF80, 16'hBF80, ADD, 16'hC000, "add_neg_neg");
    run(16'hBF40, 16'h3FE0, ADD, 16'h3F80, "add_mixed_sign");
    run(16'h4348, 16'h3A83, ADD, 16'h4348, "add_absorbed");
    run(16'h3FFF, 16'h3FE0, ADD, 16'h4070, "add_tie_even");
    run(16'h7F7F, 16'h7F7F, ADD, 16'h7F80, "add_overflow");
    run(16'h0001, 16'h3F80, ADD, 16'h3F80, "add_subnormal");
    run(16'hFF80, 16'h3F80, ADD, 16'hFF80, "add_neg_inf");
    run(16'h7FC1, 16'h3F80, ADD, 16'h7FC0, "add_nan_in");
    run(16'h3F80, 16'hBF80, MUL, 16'hBF80, "mul_one_neg");
    run(16'h0000, 16'h0000, MUL, 16'h0000, "mul_zero_zero");
    run(16'hBF80, 16'hBF80, MUL, 16'h3F80, "mul_neg_neg");
    run(16'hBF40, 16'h3FE0, MUL, 16'hBFA8, "mul_mixed");
    run(16'h4348, 16'h3A83, MUL, 16'h3E4D, "mul_round_up");
    run(16'h3FFF, 16'h3FE0, MUL, 16'h405F, "mul_round_down");
    run(16'h0080, 16'h0080, MUL, 16'h0000, "mul_underflow");
    run(16'hBF80, 16'h0000, MUL, 16'h0000, "mul_neg_times_zero");
    run(16'hFF80, 16'hBF80, MUL, 16'h7F80, "mul_inf_sign");
    run(16'h7F80, 16'hFF80, ADD, 16'h7FC0, "add_inf_minus_inf");
    run(16'h0000, 16'h7F80, MUL, 16'h7FC0, "mul_zero_inf");
    run(16'h7F00, 16'h4000, MUL, 16'h7F80, "mul_overflow");
    run(16'h3F80, 16'h3F80, 4'b0000, 16'h0000, "op_zero");
    run(16'h3F80, 16'h3F80, 4'b0011, 16'h0000, "op_other");
    run(16'h3F80, 16'h3F80, ADD, 16'h4000, "add_one_one");
    @(negedge clock);
    a = 16'hBF80;
    b = 16'hBF80;
    alu_ctrl = MUL;
    #2;
    check(16'h4000, "hold_between_edges");
    @(posedge clock);
    #1;
    check(16'h3F80, "update_after_edge");
    @(negedge clock);
    reset = 1'b1;
    a = 16'h3F80;
    b = 16'h3F80;
    alu_ctrl = ADD;
    @(posedge clock);
    #1;
    check(16'h0000, "reset_midstream");
    @(posedge clock);
    #1;
    check(16'h0000, "reset_held");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check(16'h4000, "after_release");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
